up_run_monitor: RTL and testbench
=================================

// Module: up_run_monitor
// PURPOSE
// - Parametrised run controller and monitor for the multicycle RISC-V core (UP).
// - Sequences the core reset and counts cycles and retired PC updates.
// - Detects the program halt (self-loop), watchdog timeout and exceptions.
// - Sits beside UP in simulation and FPGA top levels; replaces the fixed clock/reset stub.
// PARAMETERS
// - PC_W           64    width of PC sampled from core
// - CNT_W          32    width of cycle/instruction/exception counters
// - RST_CYCLES     2     cycles core_rst held high after rst or restart (>=1)
// - STALL_LIMIT    4     consecutive retirements at same PC that declare halt (>=1)
// - TIMEOUT_CYCLES 10000 RUN cycles before watchdog fires (0 = watchdog disabled)
// - STOP_ON_EXC    0     1: first exc_taken ends run in HALT state
// - TRACE_DEPTH    8     trace ring entries, power of 2 (used only with trace feature)
// PORTS
// - clk          in   1            system clock, rising edge
// - rst          in   1            synchronous active-high reset
// - restart      in   1            pulse: clear counters, re-run reset sequence
// - pc_write     in   1            core PCwrite; 1 = PC updated this cycle (one retirement)
// - pc_value     in   PC_W         value written to PC when pc_write=1
// - exc_taken    in   1            core entered exception (EPC load) this cycle
// - core_rst     out  1            reset driven to UP
// - running      out  1            state==RUN
// - done         out  1            state==HALT (sticky until rst/restart)
// - timeout      out  1            state==TIMEOUT (sticky until rst/restart)
// - exc_flag     out  1            sticky: any exc_taken seen since last clear
// - cycle_count  out  CNT_W        RUN cycles elapsed
// - instr_count  out  CNT_W        retirements (pc_write cycles) in RUN
// - exc_count    out  CNT_W        exc_taken cycles in RUN
// - last_pc      out  PC_W         pc_value of most recent retirement
// - trace_idx    in   log2(DEPTH)  trace read index, 0 = newest (trace feature only)
// - trace_pc     out  PC_W         trace entry at trace_idx (trace feature only)
// - trace_valid  out  1            entry at trace_idx has been written (trace feature only)
// BEHAVIOUR
// - States: HOLD, RUN, HALT, TIMEOUT. All registers are clocked on clk; outputs are registered.
// - rst=1: state=HOLD, hold counter=0, core_rst=1. All counters, last_pc and exc_flag are 0.
//   running/done/timeout=0. Trace valid bits are cleared.
// - HOLD: core_rst=1. After RST_CYCLES cycles in HOLD -> RUN; core_rst=0 from the first RUN cycle.
// - RUN, every cycle: cycle_count increments.
// - RUN, pc_write=1:
//   - instr_count increments and last_pc<=pc_value.
//   - same_cnt<=(pc_value==last_pc && instr_count!=0) ? same_cnt+1 : 0.
// - RUN, halt detection: on a pc_write where the new same_cnt==STALL_LIMIT -> HALT next cycle.
// - RUN, exc_taken=1: exc_flag<=1 and exc_count increments. If STOP_ON_EXC=1 -> HALT.
// - RUN, watchdog: the cycle where cycle_count==TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES!=0 -> TIMEOUT.
// - Priority for same-cycle events: halt/exception-stop > timeout. Both HALT and TIMEOUT are terminal.
// - HALT/TIMEOUT: all counters and last_pc freeze. pc_write and exc_taken are ignored.
//   core_rst stays 0, so the core may keep spinning.
// - All counters saturate at all-ones; no wrap.
// - restart=1 in any state: same effect as rst next cycle (core reset re-asserted, counters cleared).
//   A restart during HOLD restarts the hold count.
// - rst has priority over restart.
// - Inputs are ignored in HOLD.
// CONFIGURATION
// - Macro RUN_MONITOR_TRACE_EN.
// - Defined: ring buffer of TRACE_DEPTH PC_W entries.
//   - Each RUN retirement writes pc_value at the write pointer and advances the pointer (mod DEPTH).
//   - trace_pc = entry (wptr-1-trace_idx) mod DEPTH, combinational read.
//   - trace_valid=1 only if fewer than DEPTH retirements would not cover that slot.
//   - Cleared by rst/restart.
// - Not defined: no storage is instantiated. trace_pc=0, trace_valid=0, trace_idx is unused.
// TESTING
// - rst 1 cycle, RST_CYCLES=2 -> core_rst=1 for exactly 2 cycles after rst low; running=1 on the 3rd.
// - Retire PCs 0,4,8,C,C,C,C,C (STALL_LIMIT=4) -> done=1 the cycle after the 8th pc_write.
//   instr_count=8, last_pc=C.
// - TIMEOUT_CYCLES=20, no repeat PCs -> timeout=1 after 20 RUN cycles, cycle_count=20, then frozen.
// - STOP_ON_EXC=1, exc_taken at cycle 5 -> done=1, exc_flag=1, exc_count=1.
//   Also: halt and timeout in the same cycle -> done=1, timeout=0.
// - restart mid-RUN at instr_count=3 -> core_rst=1 for RST_CYCLES cycles; counters=0; RUN resumes.
// - With RUN_MONITOR_TRACE_EN, DEPTH=8, retire 10 PCs 0..0x24 -> trace_idx 0 gives 0x24.
//   trace_idx 7 gives 0x08; all valid.

Source files
------------

// File: rtl/up_run_monitor.sv
// Run controller/monitor for the UP multicycle core: core reset sequencing, run counters,
// halt/watchdog/exception detection. Optional PC trace ring under RUN_MONITOR_TRACE_EN.
module up_run_monitor #(
  parameter int unsigned PC_W           = 64,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned STALL_LIMIT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned STOP_ON_EXC    = 0,
  parameter int unsigned TRACE_DEPTH    = 8,
  localparam int unsigned IdxW          = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             pc_write,
  input  logic [PC_W-1:0]  pc_value,
  input  logic             exc_taken,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic             exc_flag,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] exc_count,
  output logic [PC_W-1:0]  last_pc,
  input  logic [IdxW-1:0]  trace_idx,
  output logic [PC_W-1:0]  trace_pc,
  output logic             trace_valid
);

  localparam int unsigned HoldW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SameW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {StHold, StRun, StHalt, StTimeout} state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [SameW-1:0]   same_q, same_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]   exc_q, exc_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic               exc_flag_q, exc_flag_d;
  logic               halt;
  logic               clear;

  assign clear = rst | restart;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    same_d     = same_q;
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    exc_d      = exc_q;
    last_pc_d  = last_pc_q;
    exc_flag_d = exc_flag_q;
    halt       = 1'b0;
    unique case (state_q)
      StHold: begin
        if (hold_q == HoldW'(RST_CYCLES - 1)) begin
          state_d = StRun;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        cycle_d = sat_inc(cycle_q);
        if (pc_write) begin
          instr_d   = sat_inc(instr_q);
          last_pc_d = pc_value;
          // instr_q != 0 keeps the reset value of last_pc from matching a first PC of 0
          same_d    = (pc_value == last_pc_q && instr_q != '0) ? same_q + 1'b1 : '0;
          if (same_d == SameW'(STALL_LIMIT)) halt = 1'b1;
        end
        if (exc_taken) begin
          exc_flag_d = 1'b1;
          exc_d      = sat_inc(exc_q);
          if (STOP_ON_EXC != 0) halt = 1'b1;
        end
        if (halt) begin
          state_d = StHalt;
        end else if (TIMEOUT_CYCLES != 0 && cycle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = StTimeout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StHold;
      hold_q     <= '0;
      same_q     <= '0;
      cycle_q    <= '0;
      instr_q    <= '0;
      exc_q      <= '0;
      last_pc_q  <= '0;
      exc_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      same_q     <= same_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      exc_q      <= exc_d;
      last_pc_q  <= last_pc_d;
      exc_flag_q <= exc_flag_d;
    end
  end

  assign core_rst    = (state_q == StHold);
  assign running     = (state_q == StRun);
  assign done        = (state_q == StHalt);
  assign timeout     = (state_q == StTimeout);
  assign exc_flag    = exc_flag_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign exc_count   = exc_q;
  assign last_pc     = last_pc_q;

`ifdef RUN_MONITOR_TRACE_EN
  logic [PC_W-1:0]        trace_mem_q [TRACE_DEPTH];
  logic [TRACE_DEPTH-1:0] trace_vld_q;
  logic [IdxW-1:0]        wptr_q;
  logic [IdxW-1:0]        rd_ptr;
  logic                   trace_we;

  assign trace_we = (state_q == StRun) && pc_write;

  // Storage has no reset so it can map onto distributed RAM; validity lives in trace_vld_q.
  always_ff @(posedge clk) begin
    if (trace_we && !clear) trace_mem_q[wptr_q] <= pc_value;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr_q      <= '0;
      trace_vld_q <= '0;
    end else if (trace_we) begin
      wptr_q              <= wptr_q + 1'b1;
      trace_vld_q[wptr_q] <= 1'b1;
    end
  end

  assign rd_ptr      = wptr_q - 1'b1 - trace_idx;
  assign trace_pc    = trace_mem_q[rd_ptr];
  assign trace_valid = trace_vld_q[rd_ptr];
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_idx;
  assign trace_pc         = '0;
  assign trace_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_up_run_monitor.sv
// Directed bench for up_run_monitor: three instances sharing stimulus (halt/timeout main,
// stop-on-exception, narrow counters with watchdog off).
module tb_up_run_monitor;
  localparam int unsigned PcW  = 32;
  localparam int unsigned CntW = 16;
  localparam int unsigned CntC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0, restart = 1'b0, pc_write = 1'b0, exc_taken = 1'b0;
  logic [PcW-1:0] pc_value = '0;
  logic [2:0] trace_idx = '0;

  logic a_core_rst, a_running, a_done, a_timeout, a_exc_flag, a_trace_valid;
  logic [CntW-1:0] a_cycle, a_instr, a_exc;
  logic [PcW-1:0] a_last_pc, a_trace_pc;
  logic b_core_rst, b_running, b_done, b_timeout, b_exc_flag, b_trace_valid;
  logic [CntW-1:0] b_cycle, b_instr, b_exc;
  logic [PcW-1:0] b_last_pc, b_trace_pc;
  logic c_core_rst, c_running, c_done, c_timeout, c_exc_flag, c_trace_valid;
  logic [CntC-1:0] c_cycle, c_instr, c_exc;
  logic [PcW-1:0] c_last_pc, c_trace_pc;

  int tests_run = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  up_run_monitor #(.PC_W(PcW), .CNT_W(CntW), .RST_CYCLES(2), .STALL_LIMIT(4),
    .TIMEOUT_CYCLES(20), .STOP_ON_EXC(0), .TRACE_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .restart(restart), .pc_write(pc_write), .pc_value(pc_value),
    .exc_taken(exc_taken), .core_rst(a_core_rst), .running(a_running), .done(a_done),
    .timeout(a_timeout), .exc_flag(a_exc_flag), .cycle_count(a_cycle), .instr_count(a_instr),
    .exc_count(a_exc), .last_pc(a_last_pc), .trace_idx(trace_idx), .trace_pc(a_trace_pc),
    .trace_valid(a_trace_valid));

  up_run_monitor #(.PC_W(PcW), .CNT_W(CntW), .RST_CYCLES(2), .STALL_LIMIT(4),
    .TIMEOUT_CYCLES(20), .STOP_ON_EXC(1), .TRACE_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .restart(restart), .pc_write(pc_write), .pc_value(pc_value),
    .exc_taken(exc_taken), .core_rst(b_core_rst), .running(b_running), .done(b_done),
    .timeout(b_timeout), .exc_flag(b_exc_flag), .cycle_count(b_cycle), .instr_count(b_instr),
    .exc_count(b_exc), .last_pc(b_last_pc), .trace_idx(trace_idx), .trace_pc(b_trace_pc),
    .trace_valid(b_trace_valid));

  up_run_monitor #(.PC_W(PcW), .CNT_W(CntC), .RST_CYCLES(2), .STALL_LIMIT(4),
    .TIMEOUT_CYCLES(0), .STOP_ON_EXC(0), .TRACE_DEPTH(8)) dut_c (
    .clk(clk), .rst(rst), .restart(restart), .pc_write(pc_write), .pc_value(pc_value),
    .exc_taken(exc_taken), .core_rst(c_core_rst), .running(c_running), .done(c_done),
    .timeout(c_timeout), .exc_flag(c_exc_flag), .cycle_count(c_cycle), .instr_count(c_instr),
    .exc_count(c_exc), .last_pc(c_last_pc), .trace_idx(trace_idx), .trace_pc(c_trace_pc),
    .trace_valid(c_trace_valid));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset, then wait out the two HOLD cycles; returns with all instances in RUN, cycle 0.
  task automatic start_run();
    pc_write  = 1'b0;
    exc_taken = 1'b0;
    restart   = 1'b0;
    pc_value  = '0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    tick_n(2);
  endtask

  task automatic retire(input int n);
    for (int i = 0; i < n; i++) begin
      pc_write = 1'b1;
      tick();
      pc_value = pc_value + 32'h4;
    end
    pc_write = 1'b0;
  endtask

  logic [PcW-1:0] halt_pcs [8];

  initial begin
    halt_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};

    // Reset sequence
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_core_rst", {63'd0, a_core_rst}, 64'd1);
    check("rst_running", {63'd0, a_running}, 64'd0);
    check("rst_done", {63'd0, a_done}, 64'd0);
    check("rst_timeout", {63'd0, a_timeout}, 64'd0);
    check("rst_exc_flag", {63'd0, a_exc_flag}, 64'd0);
    check("rst_cycle", 64'(a_cycle), 64'd0);
    check("rst_instr", 64'(a_instr), 64'd0);
    check("rst_last_pc", 64'(a_last_pc), 64'd0);
    tick();
    check("hold2_core_rst", {63'd0, a_core_rst}, 64'd1);
    check("hold2_running", {63'd0, a_running}, 64'd0);
    tick();
    check("run_core_rst", {63'd0, a_core_rst}, 64'd0);
    check("run_running", {63'd0, a_running}, 64'd1);

    // Halt on self-loop
    for (int i = 0; i < 8; i++) begin
      pc_write = 1'b1;
      pc_value = halt_pcs[i];
      tick();
      if (i == 6) check("halt_not_early", {63'd0, a_done}, 64'd0);
    end
    pc_write = 1'b0;
    check("halt_done", {63'd0, a_done}, 64'd1);
    check("halt_running", {63'd0, a_running}, 64'd0);
    check("halt_instr", 64'(a_instr), 64'd8);
    check("halt_last_pc", 64'(a_last_pc), 64'hC);
    check("halt_cycle", 64'(a_cycle), 64'd8);
    check("halt_c_done", {63'd0, c_done}, 64'd1);
    pc_write = 1'b1;
    pc_value = 32'h100;
    tick_n(3);
    pc_write = 1'b0;
    check("halt_frozen_instr", 64'(a_instr), 64'd8);
    check("halt_frozen_pc", 64'(a_last_pc), 64'hC);
    check("halt_frozen_cycle", 64'(a_cycle), 64'd8);

    // Watchdog, plus saturation on the narrow instance
    start_run();
    pc_value = 32'h40;
    for (int i = 0; i < 19; i++) begin
      pc_write = 1'b1;
      tick();
      pc_value = pc_value + 32'h4;
    end
    check("wd_pre_cycle", 64'(a_cycle), 64'd19);
    check("wd_pre_timeout", {63'd0, a_timeout}, 64'd0);
    tick();
    check("wd_timeout", {63'd0, a_timeout}, 64'd1);
    check("wd_running", {63'd0, a_running}, 64'd0);
    check("wd_cycle", 64'(a_cycle), 64'd20);
    check("wd_instr", 64'(a_instr), 64'd20);
    tick_n(3);
    pc_write = 1'b0;
    check("wd_frozen_cycle", 64'(a_cycle), 64'd20);
    check("wd_frozen_instr", 64'(a_instr), 64'd20);
    check("sat_cycle", 64'(c_cycle), 64'hF);
    check("sat_instr", 64'(c_instr), 64'hF);
    check("sat_running", {63'd0, c_running}, 64'd1);

    // Exception stop
    start_run();
    tick_n(5);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("exc_done", {63'd0, b_done}, 64'd1);
    check("exc_flag", {63'd0, b_exc_flag}, 64'd1);
    check("exc_count", 64'(b_exc), 64'd1);
    check("exc_cycle", 64'(b_cycle), 64'd6);
    check("exc_nostop_running", {63'd0, a_running}, 64'd1);
    check("exc_nostop_flag", {63'd0, a_exc_flag}, 64'd1);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("exc_frozen_count", 64'(b_exc), 64'd1);
    check("exc_nostop_count", 64'(a_exc), 64'd2);

    // Halt and watchdog in the same cycle
    start_run();
    tick_n(19);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("prio_done", {63'd0, b_done}, 64'd1);
    check("prio_timeout", {63'd0, b_timeout}, 64'd0);
    check("prio_cycle", 64'(b_cycle), 64'd20);
    check("prio_a_timeout", {63'd0, a_timeout}, 64'd1);

    // Restart mid-run
    start_run();
    exc_taken = 1'b1;
    retire(3);
    exc_taken = 1'b0;
    check("rs_pre_instr", 64'(a_instr), 64'd3);
    check("rs_pre_flag", {63'd0, a_exc_flag}, 64'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_core_rst", {63'd0, a_core_rst}, 64'd1);
    check("rs_instr", 64'(a_instr), 64'd0);
    check("rs_cycle", 64'(a_cycle), 64'd0);
    check("rs_last_pc", 64'(a_last_pc), 64'd0);
    check("rs_flag", {63'd0, a_exc_flag}, 64'd0);
    tick();
    check("rs_hold2", {63'd0, a_core_rst}, 64'd1);
    tick();
    check("rs_run", {63'd0, a_running}, 64'd1);

    // Restart inside HOLD restarts the count; HOLD ignores inputs
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    restart = 1'b1;
    tick();
    restart   = 1'b0;
    pc_write  = 1'b1;
    pc_value  = 32'h50;
    exc_taken = 1'b1;
    tick();
    pc_write  = 1'b0;
    exc_taken = 1'b0;
    check("hrs_core_rst", {63'd0, a_core_rst}, 64'd1);
    tick();
    check("hrs_running", {63'd0, a_running}, 64'd1);
    check("hrs_instr", 64'(a_instr), 64'd0);
    check("hrs_exc", 64'(a_exc), 64'd0);
    check("hrs_last_pc", 64'(a_last_pc), 64'd0);

    // Trace ring
    start_run();
    trace_idx = 3'd0;
    #1;
`ifdef RUN_MONITOR_TRACE_EN
    check("tr_empty_valid", {63'd0, a_trace_valid}, 64'd0);
    retire(3);
    trace_idx = 3'd3;
    #1;
    check("tr_partial_invalid", {63'd0, a_trace_valid}, 64'd0);
    trace_idx = 3'd0;
    #1;
    check("tr_partial_pc", 64'(a_trace_pc), 64'h8);
    retire(7);
    trace_idx = 3'd0;
    #1;
    check("tr_newest_pc", 64'(a_trace_pc), 64'h24);
    check("tr_newest_valid", {63'd0, a_trace_valid}, 64'd1);
    trace_idx = 3'd7;
    #1;
    check("tr_oldest_pc", 64'(a_trace_pc), 64'h8);
    check("tr_oldest_valid", {63'd0, a_trace_valid}, 64'd1);
`else
    retire(10);
    check("tr_off_pc0", 64'(a_trace_pc), 64'd0);
    check("tr_off_valid0", {63'd0, a_trace_valid}, 64'd0);
    trace_idx = 3'd7;
    #1;
    check("tr_off_pc7", 64'(a_trace_pc), 64'd0);
    check("tr_off_valid7", {63'd0, a_trace_valid}, 64'd0);
`endif
    check("tr_instr", 64'(a_instr), 64'd10);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
